debounce_multi: RTL and testbench
=================================

Name: debounce_multi

Overview:
- Parametrised N-channel successor to the single-input button debouncer, used on the board's button and switch inputs ahead of the GPU command and control logic.
- Per channel:
  - multi-stage synchroniser for the raw asynchronous input;
  - programmable-length stability filter;
  - registered debounced level;
  - one-cycle press and release pulses;
  - one-shot long-press pulse.
- Also provides a combined any-pressed flag.

Parameters:
N_CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 50000, consecutive mismatching cycles needed to accept a new level (>=1)
CNT_W, 16, debounce counter width; DEBOUNCE_CYCLES-1 must fit in CNT_W bits
LONG_PRESS_CYCLES, 5000000, cycles the debounced level must stay 1 before long_press fires (>=1)
LP_W, 23, long-press counter width; LONG_PRESS_CYCLES-1 must fit in LP_W bits

Ports:
clk  input  1  system clock
rst  input  1  reset; one clock, reset asynchronous and active-high
btn_in  input  N_CH  raw asynchronous button inputs
btn_level  output  N_CH  debounced level per channel
btn_rise  output  N_CH  one-cycle pulse on debounced 0->1
btn_fall  output  N_CH  one-cycle pulse on debounced 1->0
long_press  output  N_CH  one-cycle pulse when the level has been 1 for LONG_PRESS_CYCLES cycles
any_pressed  output  1  OR of btn_level

Behaviour:
- Reset (async assert, release sampled by clk): all sync flops, counters, btn_level, btn_rise, btn_fall, long_press and any_pressed are 0.
- Synchroniser: btn_in[i] passes through SYNC_STAGES flops; the last stage is s[i]. No logic sits between stages.
- Debounce counter cnt[i], evaluated each cycle:
  - s==btn_level: cnt<=0.
  - s!=btn_level and cnt==DEBOUNCE_CYCLES-1: btn_level<=s and cnt<=0.
  - Otherwise: cnt<=cnt+1.
  - Any single cycle with s==btn_level restarts the count (glitch rejection).
- Latency: a clean step on btn_in shows on btn_level SYNC_STAGES+DEBOUNCE_CYCLES clk edges after the first edge that samples the new value.
- Edge pulses are registered and asserted in the same cycle btn_level first shows its new value, for exactly one cycle:
  - btn_rise on a 0->1 change.
  - btn_fall on a 1->0 change.
  - btn_rise and btn_fall are never both high on one channel.
- Long press, counter lp[i]:
  - Cleared while btn_level==0.
  - While btn_level==1, increments and saturates at LONG_PRESS_CYCLES-1.
  - long_press pulses for one cycle when lp transitions to LONG_PRESS_CYCLES-1, i.e. LONG_PRESS_CYCLES cycles after btn_level rose (counting the rise cycle as the first).
  - Fires at most once per press; re-arms only after btn_level returns to 0.
  - A release before the threshold produces no pulse.
- any_pressed: registered OR of the next-state btn_level, so it is cycle-aligned with btn_level.
- Channels are fully independent; simultaneous events on several channels are each handled in the same cycle.
- Reset asserted mid-count: all state clears immediately; no pulse is emitted on reset entry or exit.
- With btn_in held at 1 through reset release, btn_level rises SYNC_STAGES+DEBOUNCE_CYCLES edges later with a btn_rise pulse.
- DEBOUNCE_CYCLES==1: a new level is accepted on the first cycle s differs from btn_level.

Decomposition:
- Package debounce_pkg holds:
  - a clog2-based width helper, used to derive recommended CNT_W and LP_W from the cycle counts;
  - elaboration-time checks that the cycle counts fit their widths.
- One natural sub-module, debounce_channel:
  - contains the synchroniser, debounce counter, level, rise/fall and long-press logic for a single bit;
  - the top generates N_CH instances and ORs the levels for any_pressed.

Test Plan (N_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, CNT_W=3, LONG_PRESS_CYCLES=10, LP_W=4):
1. Reset hold, btn_in=4'hF during reset -> all outputs 0 while rst=1. After release, btn_level=4'hF exactly 6 edges later, with btn_rise=4'hF for one cycle and any_pressed=1 in the same cycle.
2. Ch0 0->1 step held -> btn_level[0] rises 6 edges after the sampling edge, btn_rise[0] one cycle. Glitches of 1-3 cycles on ch1 -> btn_level[1] stays 0 and no pulses.
3. Ch2 bounce pattern 1,1,1,0,1,1,1,1 (per cycle) -> the count restarts at the 0, and btn_level[2] rises only after 4 consecutive synchronised 1s.
4. Ch3 held pressed 20 cycles after debounce -> long_press[3] pulses exactly once, 10 cycles after btn_rise[3]. Release then press again -> the second long_press fires. A press of 5 cycles -> no long_press.
5. Ch0 and ch1 released in the same cycle -> btn_fall=4'b0011 in one cycle; any_pressed drops in the cycle the last level clears.
6. rst asserted while ch0 cnt=2 and lp=7 -> immediate clear, no rise/fall/long_press pulse on entry or after release while btn_in=0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared helpers for the multi-channel debouncer: counter width derivation
// and elaboration-time range checks.
package debounce_pkg;

    // Bits needed to hold count-1 (never less than one bit).
    function automatic int width_for(input longint count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

    function automatic bit fits(input longint count, input int width);
        return (count >= 1) && ((count - 1) < (longint'(1) << width));
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debouncer: synchroniser, stability filter, registered level,
// rise/fall pulses and a one-shot long-press pulse.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int CNT_W             = 16,
    parameter int LONG_PRESS_CYCLES = 5000000,
    parameter int LP_W              = 23
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic level_next,
    output logic rise,
    output logic fall,
    output logic long_press
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LP_W-1:0]  LP_MAX  = LP_W'(LONG_PRESS_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [CNT_W-1:0]       cnt;
    logic [LP_W-1:0]        lp;
    logic [LP_W-1:0]        lp_next;
    logic                   lp_fire;

    assign s = sync[SYNC_STAGES-1];

    always_comb begin
        level_next = level;
        if ((s != level) && (cnt == CNT_MAX))
            level_next = s;

        // lp stays 0 in the rise cycle so that it reaches LP_MAX exactly
        // LONG_PRESS_CYCLES cycles after the rise, counting the rise cycle.
        lp_next = '0;
        if (level_next && level)
            lp_next = (lp == LP_MAX) ? lp : lp + LP_W'(1);

        lp_fire = level_next && (lp_next == LP_MAX) && !(level && (lp == LP_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync       <= '0;
            cnt        <= '0;
            level      <= 1'b0;
            rise       <= 1'b0;
            fall       <= 1'b0;
            lp         <= '0;
            long_press <= 1'b0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], btn};
            cnt        <= ((s == level) || (cnt == CNT_MAX)) ? '0 : cnt + CNT_W'(1);
            level      <= level_next;
            rise       <= level_next & ~level;
            fall       <= ~level_next & level;
            lp         <= lp_next;
            long_press <= lp_fire;
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// N-channel button/switch debouncer with per-channel edge and long-press
// pulses and a combined any-pressed flag.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int N_CH              = 4,
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 50000,
    parameter int CNT_W             = width_for(DEBOUNCE_CYCLES),
    parameter int LONG_PRESS_CYCLES = 5000000,
    parameter int LP_W              = width_for(LONG_PRESS_CYCLES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall,
    output logic [N_CH-1:0] long_press,
    output logic            any_pressed
);

    if (N_CH < 1) begin : g_bad_nch
        $error("debounce_multi: N_CH must be at least 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_multi: SYNC_STAGES must be at least 2");
    end
    if (!fits(DEBOUNCE_CYCLES, CNT_W)) begin : g_bad_cnt
        $error("debounce_multi: DEBOUNCE_CYCLES-1 does not fit in CNT_W bits");
    end
    if (!fits(LONG_PRESS_CYCLES, LP_W)) begin : g_bad_lp
        $error("debounce_multi: LONG_PRESS_CYCLES-1 does not fit in LP_W bits");
    end

    logic [N_CH-1:0] level_next;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES       (SYNC_STAGES),
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .CNT_W             (CNT_W),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
            .LP_W              (LP_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .btn        (btn_in[i]),
            .level      (btn_level[i]),
            .level_next (level_next[i]),
            .rise       (btn_rise[i]),
            .fall       (btn_fall[i]),
            .long_press (long_press[i])
        );
    end

    // Built from next-state levels so the flag lines up with btn_level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            any_pressed <= 1'b0;
        else
            any_pressed <= |level_next;
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi: constant vector table, directed
// corner-case sequences and randomized stimulus against a reference model.
module tb_debounce_multi;

    localparam int N   = 4;
    localparam int SS  = 2;
    localparam int DC  = 4;
    localparam int CW  = 3;
    localparam int LPC = 10;
    localparam int LW  = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] btn_level, btn_rise, btn_fall, long_press;
    logic         any_pressed;

    always #5 clk = ~clk;

    debounce_multi #(
        .N_CH(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .CNT_W(CW),
        .LONG_PRESS_CYCLES(LPC), .LP_W(LW)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .btn_level(btn_level),
        .btn_rise(btn_rise), .btn_fall(btn_fall), .long_press(long_press),
        .any_pressed(any_pressed)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: a level is accepted once the last DC synchronised
    // samples all disagree with it; press age counts cycles at level 1.
    bit [N-1:0] m_pipe [SS];
    bit [N-1:0] m_hist [DC];
    bit [N-1:0] m_level, m_rise, m_fall, m_lp;
    bit         m_any;
    int         m_age [N];

    task automatic model_reset();
        for (int k = 0; k < SS; k++) m_pipe[k] = '0;
        for (int k = 0; k < DC; k++) m_hist[k] = '0;
        for (int c = 0; c < N; c++) m_age[c] = 0;
        m_level = '0; m_rise = '0; m_fall = '0; m_lp = '0; m_any = 1'b0;
    endtask

    task automatic model_edge(input bit [N-1:0] din);
        bit [N-1:0] s;
        bit [N-1:0] old;
        bit         all_diff;
        s   = m_pipe[SS-1];
        old = m_level;
        for (int k = DC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = s;
        for (int c = 0; c < N; c++) begin
            all_diff = 1'b1;
            for (int k = 0; k < DC; k++)
                if (m_hist[k][c] == old[c]) all_diff = 1'b0;
            if (all_diff) m_level[c] = s[c];
            if (m_level[c]) m_age[c] = old[c] ? m_age[c] + 1 : 1;
            else            m_age[c] = 0;
            m_lp[c] = m_level[c] && (m_age[c] == LPC);
        end
        m_rise = m_level & ~old;
        m_fall = ~m_level & old;
        m_any  = |m_level;
        for (int k = SS - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
        m_pipe[0] = din;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("level", {4'b0, btn_level}, {4'b0, m_level});
        chk("rise", {4'b0, btn_rise}, {4'b0, m_rise});
        chk("fall", {4'b0, btn_fall}, {4'b0, m_fall});
        chk("long_press", {4'b0, long_press}, {4'b0, m_lp});
        chk("any_pressed", {7'b0, any_pressed}, {7'b0, m_any});
    endtask

    task automatic step(input logic [N-1:0] din);
        btn_in = din;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(din);
        #1;
        compare_all();
    endtask

    typedef struct {
        logic [N-1:0] din;
        logic [N-1:0] level;
        logic [N-1:0] rise;
        logic         any;
    } vec_t;

    vec_t         tbl [8];
    bit   [15:0]  glitch;
    bit   [11:0]  bounce;
    logic [N-1:0] base;
    logic [N-1:0] cur;
    int           rise_at, lp_at, lp_cnt, pulse_cnt, saw_rise;
    bit           found;

    initial begin
        for (int i = 0; i < 8; i++) begin
            tbl[i].din   = 4'hF;
            tbl[i].level = (i >= 5) ? 4'hF : 4'h0;
            tbl[i].rise  = (i == 5) ? 4'hF : 4'h0;
            tbl[i].any   = (i >= 5);
        end

        model_reset();

        // 1: buttons held during reset, level appears 6 edges after release
        for (int i = 0; i < 3; i++) step(4'hF);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].din);
            chk("t1_level", {4'b0, btn_level}, {4'b0, tbl[i].level});
            chk("t1_rise", {4'b0, btn_rise}, {4'b0, tbl[i].rise});
            chk("t1_any", {7'b0, any_pressed}, {7'b0, tbl[i].any});
        end
        for (int i = 0; i < 15; i++) step(4'h0);

        // 2: ch0 clean step, ch1 glitches of 1..3 cycles
        glitch = 16'h0399;
        for (int j = 0; j < 16; j++) begin
            step({2'b00, glitch[j], 1'b1});
            if (j >= 4 && j <= 6) chk("t2_level0", {7'b0, btn_level[0]}, {7'b0, (j >= 5)});
            if (j <= 7) chk("t2_rise0", {7'b0, btn_rise[0]}, {7'b0, (j == 5)});
            chk("t2_ch1_quiet", {5'b0, btn_level[1], btn_rise[1], btn_fall[1]}, 8'h00);
        end

        // 3: ch2 bounce restarts the filter
        bounce = 12'hFF7;
        for (int j = 0; j < 12; j++) begin
            step({1'b0, bounce[j], 2'b01});
            if (j == 8) chk("t3_level2_early", {7'b0, btn_level[2]}, 8'h00);
            if (j == 9) chk("t3_level2_rise", {7'b0, btn_level[2]}, 8'h01);
        end

        // 4: long press on ch3, re-arm, and a short press
        base = 4'b0001;
        rise_at = -1; lp_at = -1; lp_cnt = 0;
        for (int j = 0; j < 40; j++) begin
            step(base | 4'b1000);
            if (btn_rise[3]) rise_at = j;
            if (long_press[3]) begin lp_cnt++; lp_at = j; end
        end
        chk("t4_lp_count", 8'(lp_cnt), 8'd1);
        chk("t4_lp_offset", 8'(lp_at - rise_at), 8'(LPC - 1));
        for (int j = 0; j < 12; j++) step(base);
        lp_cnt = 0;
        for (int j = 0; j < 30; j++) begin
            step(base | 4'b1000);
            if (long_press[3]) lp_cnt++;
        end
        chk("t4_lp_rearm", 8'(lp_cnt), 8'd1);
        for (int j = 0; j < 12; j++) step(base);
        lp_cnt = 0; saw_rise = 0;
        for (int j = 0; j < 25; j++) begin
            step((j < 5) ? (base | 4'b1000) : base);
            if (btn_rise[3]) saw_rise = 1;
            if (long_press[3]) lp_cnt++;
        end
        chk("t4_short_rise", 8'(saw_rise), 8'd1);
        chk("t4_short_no_lp", 8'(lp_cnt), 8'd0);

        // 5: simultaneous release of ch0 and ch1
        for (int j = 0; j < 10; j++) step(4'b0011);
        chk("t5_levels_up", {4'b0, btn_level}, 8'h03);
        found = 1'b0;
        for (int j = 0; j < 20 && !found; j++) begin
            step(4'b0000);
            if (btn_fall != 0) begin
                found = 1'b1;
                chk("t5_fall", {4'b0, btn_fall}, 8'h03);
                chk("t5_any", {7'b0, any_pressed}, 8'h00);
                chk("t5_level", {4'b0, btn_level}, 8'h00);
            end
        end
        chk("t5_fall_seen", {7'b0, found}, 8'h01);

        // 6: reset mid-count on ch0
        found = 1'b0;
        for (int j = 0; j < 12 && !found; j++) begin
            step(4'b0001);
            if (btn_rise[0]) found = 1'b1;
        end
        chk("t6_rise_seen", {7'b0, found}, 8'h01);
        for (int j = 0; j < 3; j++) step(4'b0001);
        for (int j = 0; j < 4; j++) step(4'b0000);
        chk("t6_level_before", {7'b0, btn_level[0]}, 8'h01);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("t6_clear_level", {4'b0, btn_level}, 8'h00);
        chk("t6_clear_pulses", {btn_rise, btn_fall}, 8'h00);
        chk("t6_clear_any", {3'b0, long_press, any_pressed}, 8'h00);
        step(4'b0000);
        step(4'b0000);
        #1 rst = 1'b0;
        pulse_cnt = 0;
        for (int j = 0; j < 20; j++) begin
            step(4'b0000);
            if ((btn_rise | btn_fall | long_press) != 0) pulse_cnt++;
        end
        chk("t6_no_pulses", 8'(pulse_cnt), 8'd0);

        // Randomized: per-channel toggles with long holds
        cur = '0;
        for (int j = 0; j < 800; j++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(9) == 0) cur[c] = ~cur[c];
            step(cur);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
